// File: rtl/gcc_pkg.sv
// Shared widths and state encoding for the GCC-PHAT frame sequencer.
package gcc_pkg;

    localparam int GCC_DATA_WIDTH      = 128;
    localparam int GCC_DELAY_WIDTH     = 48;
    localparam int GCC_FRAME_IDX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        WAIT    = 2'd2,
        TIMEOUT = 2'd3
    } gcc_frame_state_t;

endpackage

// File: rtl/gcc_result_reg.sv
// Single-entry AXI-Stream output register for tagged delay results.
// A load in the same cycle as a downstream handshake presents the new value.
module gcc_result_reg #(
    parameter int DATA_W = 48,
    parameter int USER_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [USER_W-1:0] load_user,
    output logic [DATA_W-1:0] tdata,
    output logic [USER_W-1:0] tuser,
    output logic              tvalid,
    input  logic              tready
);

    logic [DATA_W-1:0] data_reg;
    logic [USER_W-1:0] user_reg;
    logic              valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            user_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= load_data;
            user_reg  <= load_user;
            valid_reg <= 1'b1;
        end else if (tready) begin
            valid_reg <= 1'b0;
        end
    end

    assign tdata  = data_reg;
    assign tuser  = user_reg;
    assign tvalid = valid_reg;

endmodule

// File: rtl/gcc_frame_ctrl.sv
// Frames the sample stream for the GCC-PHAT core and tags its delay results.
// Optional result watchdog: define GCC_FRAME_CTRL_TIMEOUT_EN.
module gcc_frame_ctrl
    import gcc_pkg::*;
#(
    parameter int FRAME_LEN      = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int DATA_WIDTH     = GCC_DATA_WIDTH,
    parameter int DELAY_WIDTH    = GCC_DELAY_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           clr_err,
    input  logic [DATA_WIDTH-1:0]          S_AXIS_IN_tdata,
    input  logic                           S_AXIS_IN_tvalid,
    output logic                           S_AXIS_IN_tready,
    output logic [DATA_WIDTH-1:0]          M_AXIS_CORE_tdata,
    output logic                           M_AXIS_CORE_tvalid,
    input  logic                           M_AXIS_CORE_tready,
    output logic                           M_AXIS_CORE_tlast,
    input  logic [DELAY_WIDTH-1:0]         S_AXIS_RES_tdata,
    input  logic                           S_AXIS_RES_tvalid,
    output logic                           S_AXIS_RES_tready,
    output logic [DELAY_WIDTH-1:0]         M_AXIS_DELAYS_tdata,
    output logic [GCC_FRAME_IDX_WIDTH-1:0] M_AXIS_DELAYS_tuser,
    output logic                           M_AXIS_DELAYS_tvalid,
    input  logic                           M_AXIS_DELAYS_tready,
    output logic                           busy,
    output logic                           err_timeout
);

    localparam int BEAT_W = $clog2(FRAME_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    gcc_frame_state_t                 state_reg;
    logic [BEAT_W-1:0]                beat_cnt_reg;
    logic [GCC_FRAME_IDX_WIDTH-1:0]   frame_idx_reg;
    logic                             drain_en_reg;
    logic                             fill;
    logic                             in_wait;
    logic                             core_hs;
    logic                             res_hs;
    logic                             wd_expired;

    assign fill    = (state_reg == FILL);
    assign in_wait = (state_reg == WAIT);

    // Zero-latency pass-through while filling; everything is gated off otherwise.
    assign M_AXIS_CORE_tvalid = fill && S_AXIS_IN_tvalid;
    assign S_AXIS_IN_tready   = fill && M_AXIS_CORE_tready;
    assign M_AXIS_CORE_tdata  = fill ? S_AXIS_IN_tdata : '0;
    assign M_AXIS_CORE_tlast  = fill && (beat_cnt_reg == LAST_BEAT);

    // Outside WAIT results are accepted and dropped so late ones drain away.
    assign S_AXIS_RES_tready = in_wait ? (!M_AXIS_DELAYS_tvalid || M_AXIS_DELAYS_tready)
                                       : drain_en_reg;

    assign core_hs = M_AXIS_CORE_tvalid && M_AXIS_CORE_tready;
    assign res_hs  = S_AXIS_RES_tvalid && S_AXIS_RES_tready;
    assign busy    = (state_reg != IDLE);

`ifdef GCC_FRAME_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (in_wait && !res_hs) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end else begin
                wd_cnt_reg <= '0;
            end
            if (state_reg == TIMEOUT) begin
                err_reg <= 1'b1;
            end else if (clr_err) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign wd_expired  = (wd_cnt_reg == WD_LAST);
    assign err_timeout = err_reg;
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign wd_expired     = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            beat_cnt_reg  <= '0;
            frame_idx_reg <= '0;
            drain_en_reg  <= 1'b0;
        end else begin
            drain_en_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg <= FILL;
                    end
                end
                FILL: begin
                    if (core_hs) begin
                        if (beat_cnt_reg == LAST_BEAT) begin
                            beat_cnt_reg <= '0;
                            state_reg    <= WAIT;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // A result arriving on the final watchdog cycle still counts.
                    if (res_hs) begin
                        frame_idx_reg <= frame_idx_reg + 1'b1;
                        state_reg     <= enable ? FILL : IDLE;
                    end else if (wd_expired) begin
                        state_reg <= TIMEOUT;
                    end
                end
                TIMEOUT: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    gcc_result_reg #(
        .DATA_W (DELAY_WIDTH),
        .USER_W (GCC_FRAME_IDX_WIDTH)
    ) u_result_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (in_wait && res_hs),
        .load_data (S_AXIS_RES_tdata),
        .load_user (frame_idx_reg),
        .tdata     (M_AXIS_DELAYS_tdata),
        .tuser     (M_AXIS_DELAYS_tuser),
        .tvalid    (M_AXIS_DELAYS_tvalid),
        .tready    (M_AXIS_DELAYS_tready)
    );

endmodule

// File: tb/tb_gcc_frame_ctrl.sv
// Directed bench for gcc_frame_ctrl with FRAME_LEN=4 and TIMEOUT_CYCLES=16.
module tb_gcc_frame_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         clr_err;
    logic [127:0] in_tdata;
    logic         in_tvalid;
    logic         in_tready;
    logic [127:0] core_tdata;
    logic         core_tvalid;
    logic         core_tready;
    logic         core_tlast;
    logic [47:0]  res_tdata;
    logic         res_tvalid;
    logic         res_tready;
    logic [47:0]  del_tdata;
    logic [15:0]  del_tuser;
    logic         del_tvalid;
    logic         del_tready;
    logic         busy;
    logic         err_timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gcc_frame_ctrl #(
        .FRAME_LEN      (4),
        .TIMEOUT_CYCLES (16),
        .DATA_WIDTH     (128),
        .DELAY_WIDTH    (48)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .enable               (enable),
        .clr_err              (clr_err),
        .S_AXIS_IN_tdata      (in_tdata),
        .S_AXIS_IN_tvalid     (in_tvalid),
        .S_AXIS_IN_tready     (in_tready),
        .M_AXIS_CORE_tdata    (core_tdata),
        .M_AXIS_CORE_tvalid   (core_tvalid),
        .M_AXIS_CORE_tready   (core_tready),
        .M_AXIS_CORE_tlast    (core_tlast),
        .S_AXIS_RES_tdata     (res_tdata),
        .S_AXIS_RES_tvalid    (res_tvalid),
        .S_AXIS_RES_tready    (res_tready),
        .M_AXIS_DELAYS_tdata  (del_tdata),
        .M_AXIS_DELAYS_tuser  (del_tuser),
        .M_AXIS_DELAYS_tvalid (del_tvalid),
        .M_AXIS_DELAYS_tready (del_tready),
        .busy                 (busy),
        .err_timeout          (err_timeout)
    );

    typedef struct {
        logic [127:0] base;
        logic [47:0]  res;
        int           delay;
        bit           rnd;
        int           drop_at;
        logic [15:0]  tuser;
        bit           busy_after;
    } frame_vec_t;

    frame_vec_t vecs[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic start_from_idle();
        @(negedge clk);
        enable = 1'b1;
        #1;
        check("idle_busy", busy, 0);
    endtask

    // Drives one 4-beat frame; the DUT must already be in FILL at the first negedge.
    task automatic send_frame(input logic [127:0] base, input bit rnd, input int drop_at);
        int beat = 0;
        int cyc  = 0;
        while (beat < 4 && cyc < 200) begin
            @(negedge clk);
            in_tvalid   = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            core_tready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            in_tdata    = base + 128'(beat);
            if (beat == drop_at) enable = 1'b0;
            #1;
            check("fill_core_tvalid", core_tvalid, in_tvalid);
            check("fill_in_tready", in_tready, core_tready);
            check("fill_tdata", core_tdata, in_tdata);
            check("fill_tlast", core_tlast, (beat == 3));
            if (in_tvalid && core_tready) beat++;
            cyc++;
        end
        check("frame_beats_done", beat, 4);
        $display("frame base=%0h beats=%0d cycles=%0d", base, beat, cyc);
    endtask

    // Waits in WAIT with upstream pushing, then returns one result and checks its tag.
    task automatic wait_result(input logic [47:0] res, input int delay,
                               input logic [15:0] tuser, input bit busy_after);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            in_tvalid   = 1'b1;
            core_tready = 1'b1;
            res_tvalid  = 1'b0;
            #1;
            check("wait_in_tready", in_tready, 0);
            check("wait_core_tvalid", core_tvalid, 0);
            check("wait_busy", busy, 1);
            if (i == 0) check("prev_result_drained", del_tvalid, 0);
        end
        @(negedge clk);
        res_tvalid = 1'b1;
        res_tdata  = res;
        #1;
        check("wait_res_tready", res_tready, 1);
        @(negedge clk);
        res_tvalid = 1'b0;
        in_tvalid  = 1'b0;
        #1;
        check("out_tvalid", del_tvalid, 1);
        check("out_tdata", del_tdata, res);
        check("out_tuser", del_tuser, tuser);
        check("busy_after_capture", busy, busy_after);
        $display("result data=%0h tuser=%0h (expected %0h)", del_tdata, del_tuser, tuser);
    endtask

    initial begin
        vecs[0] = '{128'h1000, 48'h123456789ABC, 10, 1'b0, -1, 16'd0, 1'b1};
        vecs[1] = '{128'h2000, 48'h123456789ABC, 10, 1'b0, -1, 16'd1, 1'b1};
        vecs[2] = '{128'h3000, 48'h123456789ABC, 10, 1'b0, -1, 16'd2, 1'b1};
        vecs[3] = '{128'hDEAD_BEEF_0000_0000_0000_0000_0000_4000, 48'hCAFE_0000_0001, 3, 1'b1, -1, 16'd3, 1'b1};
        vecs[4] = '{128'h5000, 48'h0000_0000_0005, 1, 1'b1, -1, 16'd4, 1'b1};
        vecs[5] = '{128'h6000, 48'hFFFF_FFFF_FFFF, 5, 1'b0, 2, 16'd5, 1'b0};

        rst_n       = 1'b0;
        enable      = 1'b0;
        clr_err     = 1'b0;
        in_tdata    = 128'hA5A5;
        in_tvalid   = 1'b1;
        core_tready = 1'b1;
        res_tdata   = 48'h1;
        res_tvalid  = 1'b1;
        del_tready  = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check("rst_in_tready", in_tready, 0);
        check("rst_core_tvalid", core_tvalid, 0);
        check("rst_core_tdata", core_tdata, 0);
        check("rst_tlast", core_tlast, 0);
        check("rst_res_tready", res_tready, 0);
        check("rst_out_tvalid", del_tvalid, 0);
        check("rst_out_tdata", del_tdata, 0);
        check("rst_out_tuser", del_tuser, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_timeout, 0);

        @(negedge clk);
        rst_n      = 1'b1;
        res_tvalid = 1'b0;
        in_tvalid  = 1'b0;
        @(negedge clk);
        #1;
        check("idle_res_tready", res_tready, 1);
        check("idle_in_tready", in_tready, 0);

        // Table of frames: continuous, backpressured, and enable dropped mid-frame.
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || !vecs[i-1].busy_after) start_from_idle();
            send_frame(vecs[i].base, vecs[i].rnd, vecs[i].drop_at);
            wait_result(vecs[i].res, vecs[i].delay, vecs[i].tuser, vecs[i].busy_after);
        end

        // Downstream stall: second result must wait for the first to drain.
        start_from_idle();
        del_tready = 1'b0;
        send_frame(128'h7000, 1'b0, -1);
        wait_result(48'h0000_AAAA_0001, 2, 16'd6, 1'b1);
        send_frame(128'h8000, 1'b0, -1);
        @(negedge clk);
        res_tvalid = 1'b1;
        res_tdata  = 48'h0000_BBBB_0002;
        in_tvalid  = 1'b1;
        #1;
        check("stall_res_tready", res_tready, 0);
        check("stall_in_tready", in_tready, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 5) enable = 1'b0;
            #1;
            check("stall_res_tready_hold", res_tready, 0);
            check("stall_out_tvalid", del_tvalid, 1);
            check("stall_out_tuser", del_tuser, 16'd6);
            check("stall_out_tdata", del_tdata, 48'h0000_AAAA_0001);
        end
        @(negedge clk);
        del_tready = 1'b1;
        #1;
        check("unstall_res_tready", res_tready, 1);
        check("unstall_out_tuser", del_tuser, 16'd6);
        @(negedge clk);
        res_tvalid = 1'b0;
        in_tvalid  = 1'b0;
        #1;
        check("load_wins_tvalid", del_tvalid, 1);
        check("load_wins_tuser", del_tuser, 16'd7);
        check("load_wins_tdata", del_tdata, 48'h0000_BBBB_0002);
        check("load_wins_busy", busy, 0);
        $display("stall sequence tuser=%0h", del_tuser);

`ifdef GCC_FRAME_CTRL_TIMEOUT_EN
        // Watchdog: no result after the frame.
        start_from_idle();
        send_frame(128'h9000, 1'b0, 2);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            #1;
            check("wd_busy", busy, 1);
            check("wd_err_low", err_timeout, 0);
        end
        @(negedge clk);
        #1;
        check("wd_err_set", err_timeout, 1);
        check("wd_idle", busy, 0);
        res_tvalid = 1'b1;
        res_tdata  = 48'h0BAD_0BAD_0BAD;
        #1;
        check("late_res_tready", res_tready, 1);
        @(negedge clk);
        res_tvalid = 1'b0;
        clr_err    = 1'b1;
        #1;
        check("late_res_discarded", del_tvalid, 0);
        check("err_sticky", err_timeout, 1);
        @(negedge clk);
        clr_err = 1'b0;
        #1;
        check("err_cleared", err_timeout, 0);
        $display("timeout sequence done");
        start_from_idle();
        send_frame(128'hA000, 1'b0, 2);
        wait_result(48'h0000_0000_0A0A, 4, 16'd8, 1'b0);
`endif

        // Frame index wrap.
        @(negedge clk);
        force dut.frame_idx_reg = 16'hFFFF;
        @(negedge clk);
        release dut.frame_idx_reg;
        start_from_idle();
        send_frame(128'hB000, 1'b0, -1);
        wait_result(48'h0000_0000_0B0B, 2, 16'hFFFF, 1'b1);
        send_frame(128'hC000, 1'b0, 2);
        wait_result(48'h0000_0000_0C0C, 2, 16'h0000, 1'b0);

        // Reset in the middle of a frame.
        start_from_idle();
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            in_tvalid   = 1'b1;
            core_tready = 1'b1;
            in_tdata    = 128'hD000 + 128'(b);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_tready", in_tready, 0);
        check("midrst_core_tvalid", core_tvalid, 0);
        check("midrst_core_tdata", core_tdata, 0);
        check("midrst_tlast", core_tlast, 0);
        check("midrst_res_tready", res_tready, 0);
        check("midrst_out_tvalid", del_tvalid, 0);
        check("midrst_out_tuser", del_tuser, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        enable    = 1'b1;
        in_tvalid = 1'b0;
        send_frame(128'hE000, 1'b0, 2);
        wait_result(48'h0000_0000_0E0E, 2, 16'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
